// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: op codes, FSM encoding, default widths.
package alu_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_OP_WIDTH   = 4;
  localparam int DEFAULT_SHAMT_W    = 5;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_AND  = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLL  = 4'b0101;
  localparam logic [3:0] OP_SRL  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;
  localparam logic [3:0] OP_MUL  = 4'b1010;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_MUL   = 2'd2
  } state_t;

  function automatic logic is_shift_op(input logic [3:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/alu_iter_mul.sv
// Iterative shift-add multiplier: one multiplier bit (LSB first) per step,
// DATA_WIDTH steps per product, low DATA_WIDTH bits kept.
module alu_iter_mul #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  step,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] product,
  output logic                  last
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  logic [DATA_WIDTH-1:0] acc;
  logic [DATA_WIDTH-1:0] mcand;
  logic [DATA_WIDTH-1:0] mplier;
  logic [CNT_W-1:0]      cnt;

  // Accumulator value after the current step; on the final step this is the product.
  assign product = acc + (mplier[0] ? mcand : '0);
  assign last    = (cnt == CNT_W'(1));

  // Load operands on start, then add/shift once per step until the counter empties.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (load) begin
      acc    <= '0;
      mcand  <= a;
      mplier <= b;
      cnt    <= CNT_W'(DATA_WIDTH);
    end else if (step) begin
      acc    <= product;
      mcand  <= {mcand[DATA_WIDTH-2:0], 1'b0};
      mplier <= {1'b0, mplier[DATA_WIDTH-1:1]};
      cnt    <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/alu_multicycle.sv
// Multi-cycle execute-stage ALU with start/busy/done handshake.
// Logic/arith ops take one cycle; shifts iterate one bit per cycle.
// Optional iterative multiplier for op 1010 is built when ALU_MUL_EN is defined.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int OP_WIDTH   = DEFAULT_OP_WIDTH,
  parameter int SHAMT_W    = DEFAULT_SHAMT_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic [OP_WIDTH-1:0]   ALU_Operation_i,
  input  logic [DATA_WIDTH-1:0] A_i,
  input  logic [DATA_WIDTH-1:0] B_i,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  zero_o,
  output logic                  busy_o,
  output logic                  done_o
);

  state_t                state, next_state;
  logic [OP_WIDTH-1:0]   op_q;
  logic [DATA_WIDTH-1:0] shift_reg, shift_next, simple_result, result_d;
  logic [SHAMT_W-1:0]    shift_cnt, shamt;
  logic                  shift_load, shift_step, shift_last, simple_done, finish;
  logic                  mul_finish;
  logic [DATA_WIDTH-1:0] mul_result;

  assign shamt      = B_i[SHAMT_W-1:0];
  assign shift_last = (shift_cnt == SHAMT_W'(1));
  assign busy_o     = (state != ST_IDLE);
  assign zero_o     = (result_o == '0);

`ifdef ALU_MUL_EN
  logic mul_load, mul_step, mul_last;

  alu_iter_mul #(.DATA_WIDTH(DATA_WIDTH)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .load    (mul_load),
    .step    (mul_step),
    .a       (A_i),
    .b       (B_i),
    .product (mul_result),
    .last    (mul_last)
  );

  assign mul_finish = mul_step & mul_last;
`else
  assign mul_result = '0;
  assign mul_finish = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  // Next-state and control strobes; a request is only looked at in IDLE.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    next_state  = state;
    simple_done = 1'b0;
    shift_load  = 1'b0;
    shift_step  = 1'b0;
`ifdef ALU_MUL_EN
    mul_load    = 1'b0;
    mul_step    = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (start_i) begin
          if (is_shift_op(ALU_Operation_i) && (shamt != '0)) begin
            shift_load = 1'b1;
            next_state = ST_SHIFT;
          end
`ifdef ALU_MUL_EN
          else if (ALU_Operation_i == OP_MUL) begin
            mul_load   = 1'b1;
            next_state = ST_MUL;
          end
`endif
          else begin
            simple_done = 1'b1;
          end
        end
      end
      ST_SHIFT: begin
        shift_step = 1'b1;
        if (shift_last) next_state = ST_IDLE;
      end
`ifdef ALU_MUL_EN
      ST_MUL: begin
        mul_step = 1'b1;
        if (mul_last) next_state = ST_IDLE;
      end
`endif
      default: next_state = ST_IDLE;
    endcase
  end

  // Single-cycle results; a shift by zero passes A straight through.
  always_comb begin
    simple_result = '0;
    case (ALU_Operation_i)
      OP_ADD:  simple_result = A_i + B_i;
      OP_OR:   simple_result = A_i | B_i;
      OP_SUB:  simple_result = A_i - B_i;
      OP_AND:  simple_result = A_i & B_i;
      OP_XOR:  simple_result = A_i ^ B_i;
      OP_SLL,
      OP_SRL,
      OP_SRA:  simple_result = A_i;
      OP_SLT:  simple_result = DATA_WIDTH'($signed(A_i) < $signed(B_i));
      OP_SLTU: simple_result = DATA_WIDTH'(A_i < B_i);
      default: simple_result = '0;
    endcase
  end

  // One-bit shift step for the latched shift op; SRA replicates the sign bit.
  always_comb begin
    case (op_q)
      OP_SLL:  shift_next = {shift_reg[DATA_WIDTH-2:0], 1'b0};
      OP_SRA:  shift_next = {shift_reg[DATA_WIDTH-1], shift_reg[DATA_WIDTH-1:1]};
      default: shift_next = {1'b0, shift_reg[DATA_WIDTH-1:1]};
    endcase
  end

  // Select the value written to result_o on the completing edge.
  always_comb begin
    finish = simple_done | (shift_step & shift_last) | mul_finish;
    if (simple_done)     result_d = simple_result;
    else if (shift_step) result_d = shift_next;
    else                 result_d = mul_result;
  end

  // Datapath registers: result/done on completion, shifter load and iteration.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_o  <= '0;
      done_o    <= 1'b0;
      shift_reg <= '0;
      shift_cnt <= '0;
      op_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register here samples pre-edge values.
      done_o <= finish;
      if (finish) result_o <= result_d;
      if (shift_load) begin
        shift_reg <= A_i;
        shift_cnt <= shamt;
        op_q      <= ALU_Operation_i;
      end else if (shift_step) begin
        shift_reg <= shift_next;
        shift_cnt <= shift_cnt - SHAMT_W'(1);
      end
    end
  end

endmodule
